// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use/branch hazards and data-memory wait sequencing
// Optional stall performance counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_WAIT   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  LoadE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  MemAccessM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [CNT_W-1:0]      StallCount
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
  localparam bit         MEM_SLOW  = (MEM_WAIT > 0);

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;
  logic       mem_stall;
  logic       load_use;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign load_use = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= RUN;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Entry cycle counts as the first stall; WAIT covers the remaining MEM_WAIT-1,
  // so WAIT exits once the decrement would reach zero.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    mem_stall     = 1'b0;
    case (state)
      RUN: begin
        if (MemAccessM && MEM_SLOW) begin
          mem_stall     = 1'b1;
          wait_cnt_next = WAIT_LOAD;
          state_next    = (WAIT_LOAD == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        mem_stall     = 1'b1;
        wait_cnt_next = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_next = DONE;
      end
      DONE: begin
        state_next = RUN;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = load_use;
      StallD = load_use && !PCSrcE;
      FlushE = load_use || PCSrcE;
      FlushD = PCSrcE;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge CLK) begin
    if (!RST)                             stall_cnt <= '0;
    else if (StallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;

  localparam int REG_ADDR_W = 5;
  localparam int MEM_WAIT   = 2;
  localparam int CNT_W      = 16;

  typedef struct {
    logic                  rst;
    logic [REG_ADDR_W-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic                  loade, regwm, regww, pcsrc, mem;
  } in_t;

  typedef struct {
    logic [1:0]       fa, fb;
    logic             sf, sd, se, sm, fd, fe, fw;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                  LoadE, RegWriteM, RegWriteW, PCSrcE, MemAccessM;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [CNT_W-1:0]      StallCount;

  int tests  = 0;
  int failed = 0;

  exp_t sb[$];

  int rem     = 0;
  bit in_done = 0;
  int cnt_m   = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .StallCount(StallCount)
  );

  function automatic logic [1:0] fwd(input in_t s, input logic [REG_ADDR_W-1:0] rs);
    if (s.regwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.regww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 'rem' counts memory-stall cycles still owed to the access in M.
  task automatic step(input in_t s);
    exp_t e;
    bit   lu, stall, next_done;
    RST = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; LoadE = s.loade;
    RegWriteM = s.regwm; RegWriteW = s.regww; PCSrcE = s.pcsrc; MemAccessM = s.mem;

    if (!in_done && rem == 0 && s.mem && MEM_WAIT > 0) rem = MEM_WAIT;
    stall = (rem > 0);
    lu = s.loade && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    e.fa  = fwd(s, s.rs1e);
    e.fb  = fwd(s, s.rs2e);
    e.sf  = stall ? 1'b1 : lu;
    e.sd  = stall ? 1'b1 : (lu && !s.pcsrc);
    e.se  = stall;
    e.sm  = stall;
    e.fw  = stall;
    e.fd  = stall ? 1'b0 : s.pcsrc;
    e.fe  = stall ? 1'b0 : (lu || s.pcsrc);
    e.cnt = CNT_W'(cnt_m);
    sb.push_back(e);

    next_done = 0;
    if (stall) begin
      rem--;
      if (rem == 0) next_done = 1;
    end
`ifdef HAZARD_STALL_CNT_EN
    if (e.sf && cnt_m < (2**CNT_W) - 1) cnt_m++;
`endif
    if (!s.rst) begin
      rem = 0; next_done = 0; cnt_m = 0;
    end
    in_done = next_done;
    @(posedge CLK); #1;
  endtask

  function automatic in_t quiet();
    in_t s;
    s = '{rst: 1'b1, default: '0};
    return s;
  endfunction

  function automatic in_t rnd();
    in_t s;
    s.rst   = ($urandom_range(0, 99) >= 3);
    s.rs1d  = REG_ADDR_W'($urandom_range(0, 3));
    s.rs2d  = REG_ADDR_W'($urandom_range(0, 3));
    s.rs1e  = REG_ADDR_W'($urandom_range(0, 3));
    s.rs2e  = REG_ADDR_W'($urandom_range(0, 3));
    s.rde   = REG_ADDR_W'($urandom_range(0, 3));
    s.rdm   = REG_ADDR_W'($urandom_range(0, 3));
    s.rdw   = REG_ADDR_W'($urandom_range(0, 3));
    s.loade = ($urandom_range(0, 9) < 3);
    s.regwm = $urandom_range(0, 1) == 1;
    s.regww = $urandom_range(0, 1) == 1;
    s.pcsrc = ($urandom_range(0, 9) < 2);
    s.mem   = ($urandom_range(0, 9) < 2);
    return s;
  endfunction

  exp_t m;
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      check("ForwardAE", ForwardAE, m.fa);
      check("ForwardBE", ForwardBE, m.fb);
      check("StallF", StallF, m.sf);
      check("StallD", StallD, m.sd);
      check("StallE", StallE, m.se);
      check("StallM", StallM, m.sm);
      check("FlushD", FlushD, m.fd);
      check("FlushE", FlushE, m.fe);
      check("FlushW", FlushW, m.fw);
      check("StallCount", StallCount, m.cnt);
    end
  end

  initial begin
    in_t s;
    int  guard;
    RST = 1'b0; Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemAccessM = 0;
    @(posedge CLK); #1;

    s = quiet(); s.rst = 0; step(s);
    s = quiet(); step(s);

    s = quiet(); s.regwm = 1; s.rdm = 5; s.rs1e = 5; step(s);
    s = quiet(); s.regww = 1; s.rdw = 5; s.rs1e = 5; step(s);
    s = quiet(); s.regwm = 1; s.rdm = 0; s.rs1e = 0; step(s);
    s = quiet(); s.regwm = 1; s.regww = 1; s.rdm = 6; s.rdw = 6; s.rs2e = 6; step(s);

    s = quiet(); s.loade = 1; s.rde = 7; s.rs2d = 7; step(s);
    s = quiet(); step(s);
    s = quiet(); s.loade = 1; s.rde = 0; s.rs1d = 0; step(s);
    s = quiet(); s.pcsrc = 1; step(s);
    s = quiet(); s.pcsrc = 1; s.loade = 1; s.rde = 3; s.rs1d = 3; step(s);

    s = quiet(); s.mem = 1;
    repeat (3) step(s);
    s = quiet(); step(s);

    s = quiet(); s.mem = 1; step(s);
    s.pcsrc = 1; step(s);
    s.mem = 0; step(s);
    s = quiet(); step(s);

    s = quiet(); s.mem = 1; repeat (4) step(s);
    s = quiet(); step(s);

    s = quiet(); s.mem = 1; step(s);
    s.rst = 0; step(s);
    s = quiet(); step(s);

    repeat (3000) step(rnd());
    s = quiet(); repeat (4) step(s);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge CLK); guard++;
    end
    if (sb.size() > 0) begin
      tests++; failed++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
